// File: rtl/multisim_apb_pkg.sv
// Shared types for the APB phase tracker and the server modules around it.
package multisim_apb_pkg;

  // APB transfer phase; encoding 2'd3 is unused and treated as illegal.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } multisim_apb_state_t;

endpackage

// File: rtl/multisim_apb_fsm.sv
// APB phase tracker: follows IDLE/SETUP/ACCESS, offers one request per
// transfer to a downstream consumer, flags protocol errors and ACCESS
// timeouts, and counts completed transfers.
module multisim_apb_fsm
  import multisim_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned COUNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_apb_psel,
  input  logic                   i_apb_penable,
  input  logic                   i_apb_pready,
  input  logic                   i_request_rdy,
  output multisim_apb_state_t    o_state,
  output logic                   o_request_vld,
  output logic                   o_busy,
  output logic                   o_protocol_err,
  output logic                   o_timeout,
  output logic [COUNT_WIDTH-1:0] o_xfer_count
);

  // Wide enough to hold TIMEOUT_CYCLES itself, since the counter saturates there.
  localparam int unsigned      TMO_W     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  multisim_apb_state_t    state_d;
  logic                   request_vld_d;
  logic                   protocol_err_d;
  logic                   timeout_d;
  logic [COUNT_WIDTH-1:0] xfer_count_d;
  logic [TMO_W-1:0]       access_cnt_q;
  logic [TMO_W-1:0]       access_cnt_d;

  // Busy is the only output decoded straight from the phase register.
  assign o_busy = (o_state != IDLE);

  // Next-state, next-output and counter logic for one clock.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    state_d        = IDLE;
    request_vld_d  = 1'b0;
    protocol_err_d = 1'b0;
    timeout_d      = 1'b0;
    xfer_count_d   = o_xfer_count;
    access_cnt_d   = access_cnt_q;

    case (o_state)
      IDLE: begin
        protocol_err_d = i_apb_psel & i_apb_penable;
        if (i_apb_psel) begin
          state_d       = SETUP;
          request_vld_d = 1'b1;
        end
      end

      SETUP: begin
        // The request is always offered in SETUP, so a ready here completes the handshake.
        state_d       = ACCESS;
        request_vld_d = ~i_request_rdy;
        access_cnt_d  = '0;
      end

      ACCESS: begin
        if (i_apb_pready) begin
          // Completion wins over a simultaneously dropped psel.
          xfer_count_d = o_xfer_count + 1'b1;
        end else if (!i_apb_psel) begin
          protocol_err_d = 1'b1;
        end else begin
          state_d       = ACCESS;
          request_vld_d = o_request_vld & ~i_request_rdy;
          if ((TIMEOUT_CYCLES != 0) && (access_cnt_q != TMO_LIMIT)) begin
            access_cnt_d = access_cnt_q + 1'b1;
            timeout_d    = (access_cnt_q == TMO_LIMIT - 1'b1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset aborts any transfer silently.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      o_state        <= IDLE;
      o_request_vld  <= 1'b0;
      o_protocol_err <= 1'b0;
      o_timeout      <= 1'b0;
      o_xfer_count   <= '0;
      access_cnt_q   <= '0;
    end else begin
      o_state        <= state_d;
      o_request_vld  <= request_vld_d;
      o_protocol_err <= protocol_err_d;
      o_timeout      <= timeout_d;
      o_xfer_count   <= xfer_count_d;
      access_cnt_q   <= access_cnt_d;
    end
  end

endmodule

// File: tb/tb_multisim_apb_fsm.sv
// Bench for multisim_apb_fsm: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_multisim_apb_fsm;
  import multisim_apb_pkg::*;

  localparam int TMO = 4;
  localparam int CW  = 4;

  logic                clk = 1'b0;
  logic                rst, psel, penable, pready, rdy;
  multisim_apb_state_t st;
  logic                vld, busy, perr, tmo;
  logic [CW-1:0]       xcnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase of the current transfer plus its bookkeeping.
  multisim_apb_state_t m_phase;
  bit m_vld, m_perr, m_tmo;
  int m_cnt, m_wait;

  // Observed pulse/strobe tallies, cleared per scenario.
  int seen_vld, seen_perr, seen_tmo;

  multisim_apb_fsm #(.TIMEOUT_CYCLES(TMO), .COUNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_apb_psel    (psel),
    .i_apb_penable (penable),
    .i_apb_pready  (pready),
    .i_request_rdy (rdy),
    .o_state       (st),
    .o_request_vld (vld),
    .o_busy        (busy),
    .o_protocol_err(perr),
    .o_timeout     (tmo),
    .o_xfer_count  (xcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    m_perr = 1'b0;
    m_tmo  = 1'b0;
    if (rst) begin
      m_phase = IDLE; m_vld = 1'b0; m_cnt = 0; m_wait = 0;
    end else begin
      case (m_phase)
        IDLE: begin
          m_perr = psel && penable;
          m_vld  = psel;
          if (psel) m_phase = SETUP;
        end
        SETUP: begin
          m_phase = ACCESS;
          m_vld   = !rdy;
          m_wait  = 0;
        end
        default: begin
          if (pready) begin
            m_cnt   = (m_cnt + 1) % (1 << CW);
            m_phase = IDLE;
            m_vld   = 1'b0;
          end else if (!psel) begin
            m_perr  = 1'b1;
            m_phase = IDLE;
            m_vld   = 1'b0;
          end else begin
            if (m_vld && rdy) m_vld = 1'b0;
            if (TMO != 0 && m_wait < TMO) begin
              m_wait++;
              m_tmo = (m_wait == TMO);
            end
          end
        end
      endcase
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every output.
  task automatic cycle(input bit r, input bit ps, input bit pe, input bit pr, input bit rd);
    rst = r; psel = ps; penable = pe; pready = pr; rdy = rd;
    model_step();
    @(posedge clk);
    #1;
    check("state", st, m_phase);
    check("request_vld", vld, m_vld);
    check("busy", busy, m_phase != IDLE);
    check("protocol_err", perr, m_perr);
    check("timeout", tmo, m_tmo);
    check("xfer_count", xcnt, m_cnt);
    seen_vld  += vld;
    seen_perr += perr;
    seen_tmo  += tmo;
  endtask

  task automatic clear_seen();
    seen_vld = 0; seen_perr = 0; seen_tmo = 0;
  endtask

  initial begin
    m_phase = IDLE; m_vld = 0; m_perr = 0; m_tmo = 0; m_cnt = 0; m_wait = 0;
    clear_seen();

    // Reset with busy inputs: all must be ignored.
    cycle(1, 1, 1, 1, 1);
    cycle(1, 1, 0, 0, 1);
    check("reset_count", xcnt, 0);

    // Single transfer: psel c0, rdy c1, pready c3.
    clear_seen();
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 1);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 0);
    check("single_state", st, IDLE);
    check("single_vld_cycles", seen_vld, 1);
    check("single_count", xcnt, 1);

    // Five back-to-back transfers, pready on the second ACCESS cycle.
    clear_seen();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 1, 0, 1'($urandom_range(0, 1)));
      cycle(0, 1, 1, 0, 1);
      cycle(0, 1, 1, 1, 0);
    end
    check("b2b_count", xcnt, 6);
    check("b2b_no_err", seen_perr, 0);

    // Timeout: pready withheld, late handshake, then completion.
    clear_seen();
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 1, 1, 0, i == 2);
    check("tmo_pulses", seen_tmo, 1);
    check("tmo_still_access", st, ACCESS);
    cycle(0, 1, 1, 1, 0);
    check("tmo_done_state", st, IDLE);
    check("tmo_done_count", xcnt, 7);

    // psel dropped in ACCESS without pready.
    clear_seen();
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("drop_err_pulses", seen_perr, 1);
    check("drop_state", st, IDLE);
    check("drop_count", xcnt, 7);
    cycle(0, 0, 0, 0, 0);
    check("drop_err_one_cycle", perr, 0);

    // psel and penable together in IDLE.
    clear_seen();
    cycle(0, 1, 1, 0, 0);
    check("idle_pe_err", perr, 1);
    check("idle_pe_state", st, SETUP);
    cycle(0, 1, 1, 0, 1);
    cycle(0, 1, 1, 1, 0);

    // Reset during ACCESS with the request still pending.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    check("pre_rst_vld", vld, 1);
    clear_seen();
    cycle(1, 0, 0, 1, 1);
    check("rst_state", st, IDLE);
    check("rst_count", xcnt, 0);
    check("rst_no_pulse", seen_perr + seen_tmo, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 85,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < 25,
            1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multisim_apb_fsm.md
MULTISIM_APB_FSM -- requirements
Module: multisim_apb_fsm

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: number of ACCESS cycles without pready before a timeout; 0 disables the timeout.
REQ-002 SHALL have parameter COUNT_WIDTH, default 32: width of the completed-transfer counter.
REQ-003 SHALL use one clock and one reset; the reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port i_apb_psel, input, 1 bit: APB select from the requester.
REQ-007 SHALL have port i_apb_penable, input, 1 bit: APB enable from the requester.
REQ-008 SHALL have port i_apb_pready, input, 1 bit: transfer-complete strobe from the response path.
REQ-009 SHALL have port i_request_rdy, input, 1 bit: the request consumer accepts o_request_vld.
REQ-010 SHALL have port o_state, output, 2 bits: current phase, of type multisim_apb_state_t.
REQ-011 SHALL have port o_request_vld, output, 1 bit: request offered to the consumer.
REQ-012 SHALL have port o_busy, output, 1 bit: high whenever o_state is not IDLE.
REQ-013 SHALL have port o_protocol_err, output, 1 bit: one-cycle pulse on an APB protocol violation.
REQ-014 SHALL have port o_timeout, output, 1 bit: one-cycle pulse when an ACCESS phase exceeds TIMEOUT_CYCLES.
REQ-015 SHALL have port o_xfer_count, output, COUNT_WIDTH bits: number of completed transfers.

Function
REQ-016 SHALL register o_state, with encoding IDLE=0, SETUP=1, ACCESS=2; encoding 3 is illegal and SHALL return to IDLE on the next edge.
REQ-017 In IDLE with i_apb_psel=1, the next state SHALL be SETUP; otherwise the FSM SHALL stay in IDLE.
REQ-018 In IDLE, i_apb_psel=1 together with i_apb_penable=1 SHALL pulse o_protocol_err, and the FSM SHALL still go to SETUP.
REQ-019 SETUP SHALL always advance to ACCESS after exactly one cycle.
REQ-020 In ACCESS with i_apb_pready=1, the next state SHALL be IDLE, and o_xfer_count SHALL increment by 1, wrapping at 2^COUNT_WIDTH.
REQ-021 In ACCESS with i_apb_psel=0 and i_apb_pready=0, the FSM SHALL pulse o_protocol_err and go to IDLE without incrementing o_xfer_count.
REQ-022 pready SHALL take priority over psel=0 when both occur in the same ACCESS cycle; that cycle counts as a completion and is not an error.
REQ-023 o_request_vld SHALL be 1 in every SETUP cycle.
REQ-024 In ACCESS, o_request_vld SHALL hold its previous value until the first edge on which o_request_vld=1 and i_request_rdy=1, after which it SHALL be 0.
REQ-025 o_request_vld SHALL be 0 in IDLE; exactly one request handshake SHALL occur per transfer.
REQ-026 If i_request_rdy=1 already in SETUP, the handshake SHALL complete at the SETUP to ACCESS edge, and o_request_vld SHALL be 0 throughout ACCESS.
REQ-027 An ACCESS-cycle counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without pready.
REQ-028 When that counter reaches TIMEOUT_CYCLES (with TIMEOUT_CYCLES nonzero), o_timeout SHALL pulse once, the FSM SHALL remain in ACCESS, and the counter SHALL saturate.
REQ-029 o_busy SHALL be combinational from o_state; all other outputs SHALL be registered.

Reset
REQ-030 While rst=1 at a clock edge, the next state SHALL be: o_state=IDLE, o_request_vld=0, o_busy=0, o_protocol_err=0, o_timeout=0, o_xfer_count=0, ACCESS-cycle counter=0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer with no error or timeout pulse and no count increment.
REQ-032 All inputs SHALL be ignored while rst=1.

Structure
REQ-033 Package multisim_apb_pkg SHALL hold the multisim_apb_state_t enum (IDLE, SETUP, ACCESS) so that server modules can share it.
REQ-034 The block SHALL be a single module with no sub-modules; the timeout counter width SHALL be derived from TIMEOUT_CYCLES via $clog2.

Verification
REQ-035 Scenario: single transfer with psel at cycle 0, rdy=1 at cycle 1, pready at cycle 3 -> states IDLE, SETUP, ACCESS, ACCESS, IDLE; o_request_vld high for exactly 1 cycle; o_xfer_count=1.
REQ-036 Scenario: 5 back-to-back transfers with pready after 2 ACCESS cycles each -> o_xfer_count=5, o_protocol_err never asserted.
REQ-037 Scenario: TIMEOUT_CYCLES=4 and pready withheld -> o_timeout pulses once, 4 cycles after ACCESS entry; a later pready returns the FSM to IDLE with count incremented.
REQ-038 Scenario: psel dropped in ACCESS without pready -> o_protocol_err pulses 1 cycle, FSM returns to IDLE, count unchanged.
REQ-039 Scenario: psel and penable both high in IDLE -> o_protocol_err pulse and entry to SETUP.
REQ-040 Scenario: rst asserted during ACCESS with o_request_vld=1 -> next cycle IDLE, all outputs 0, no pulses.
